// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed storage behind a small store buffer.
// Stores are queued, then written to storage when no load is using the port
// or when the buffer is full. Loads are forwarded from the youngest matching
// queued store. Invalid requests raise a sticky error flag.
module dmem_responder #(
    parameter int N        = 64,
    parameter int WORDS    = 64,
    parameter int WB_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] DM_readData,
    output logic [2:0]   wb_count,
    output logic         access_err
);

    localparam int          IW         = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int          PW         = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned DEPTH_U    = WB_DEPTH;
    localparam logic [N-1:0] ADDR_LIMIT = N'(8 * WORDS);
    localparam logic [2:0]  FULL       = 3'(WB_DEPTH);

    logic [N-1:0]  mem_q     [WORDS];
    logic [N-1:0]  mem_d     [WORDS];
    logic [IW-1:0] wb_idx_q  [WB_DEPTH];
    logic [IW-1:0] wb_idx_d  [WB_DEPTH];
    logic [N-1:0]  wb_data_q [WB_DEPTH];
    logic [N-1:0]  wb_data_d [WB_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [2:0]    count_q, count_d;
    logic          err_q, err_d;

    logic          req;
    logic          valid;
    logic [IW-1:0] idx;
    logic          drain;
    logic          enq;
    logic [N-1:0]  fwd_data;

    // Pointer advance with explicit wrap at WB_DEPTH-1, so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= DEPTH_U) s = s - DEPTH_U;
        return PW'(s);
    endfunction

    // Request decode: alignment, range and single-operation checks.
    always_comb begin
        req   = DM_writeEnable | DM_readEnable;
        valid = req && !(DM_writeEnable && DM_readEnable) &&
                (DM_addr[2:0] == 3'b000) && (DM_addr < ADDR_LIMIT);
        idx   = DM_addr[IW+2:3];
        drain = (count_q != 3'd0) && (!DM_readEnable || count_q == FULL);
        enq   = DM_writeEnable && valid;
    end

    // Load path: storage value overridden by queued stores, oldest to youngest,
    // so the last match (youngest, including one draining this edge) wins.
    always_comb begin
        fwd_data = mem_q[idx];
        for (int unsigned k = 0; k < DEPTH_U; k++) begin
            if (k < 32'(count_q)) begin
                if (wb_idx_q[ptr_add(head_q, k)] == idx) fwd_data = wb_data_q[ptr_add(head_q, k)];
            end
        end
        DM_readData = (reset && DM_readEnable && valid) ? fwd_data : '0;
    end

    // Next state: drain the head into storage, enqueue at the tail, track count and error.
    always_comb begin
        mem_d     = mem_q;
        wb_idx_d  = wb_idx_q;
        wb_data_d = wb_data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        err_d     = err_q;
        if (drain) begin
            mem_d[wb_idx_q[head_q]] = wb_data_q[head_q];
            head_d = ptr_add(head_q, 1);
        end
        if (enq) begin
            wb_idx_d[tail_q]  = idx;
            wb_data_d[tail_q] = DM_writeData;
            tail_d = ptr_add(tail_q, 1);
        end
        if (enq && !drain) begin
            count_d = count_q + 3'd1;
        end else if (!enq && drain) begin
            count_d = count_q - 3'd1;
        end
        if (req && !valid) err_d = 1'b1;
    end

    // State registers; reset reloads storage with its own index and drops queued stores.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < WORDS; i++) mem_q[i] <= N'(i);
            for (int unsigned j = 0; j < DEPTH_U; j++) begin
                wb_idx_q[j]  <= '0;
                wb_data_q[j] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wb_idx_q  <= wb_idx_d;
            wb_data_q <= wb_data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign wb_count   = count_q;
    assign access_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a queue-based reference model predicts
// load data and post-edge status; a negedge monitor compares.
module tb_dmem_responder;

    localparam int N        = 64;
    localparam int WORDS    = 64;
    localparam int WB_DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_writeEnable;
    logic         DM_readEnable;
    logic [N-1:0] DM_readData;
    logic [2:0]   wb_count;
    logic         access_err;

    dmem_responder #(.N(N), .WORDS(WORDS), .WB_DEPTH(WB_DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .DM_writeEnable (DM_writeEnable),
        .DM_readEnable  (DM_readEnable),
        .DM_readData    (DM_readData),
        .wb_count       (wb_count),
        .access_err     (access_err)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; logic [N-1:0] data; } wb_ent_t;
    typedef struct { int cnt; bit err; } st_t;

    // Reference model state
    logic [N-1:0] m_mem [WORDS];
    wb_ent_t      m_buf [$];
    bit           m_err;

    // Scoreboard queues
    logic [N-1:0] rd_q [$];
    st_t          st_q [$];

    int checks = 0;
    int errors = 0;

    function automatic bit addr_ok(input bit we, input bit re, input logic [N-1:0] a);
        return (we != re) && (a[2:0] == 3'b000) && (a < 64'(8 * WORDS));
    endfunction

    function automatic logic [N-1:0] exp_read(input bit rst_n, input bit we, input bit re,
                                              input logic [N-1:0] a);
        logic [N-1:0] r;
        int ix;
        if (!rst_n || !re || !addr_ok(we, re, a)) return '0;
        ix = int'(a / 8);
        r = m_mem[ix];
        foreach (m_buf[k]) if (m_buf[k].idx == ix) r = m_buf[k].data;
        return r;
    endfunction

    task automatic model_edge(input bit rst_n, input bit we, input bit re,
                              input logic [N-1:0] a, input logic [N-1:0] wd);
        bit ok;
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) m_mem[i] = 64'(i);
            m_buf.delete();
            m_err = 1'b0;
            return;
        end
        ok = addr_ok(we, re, a);
        if (m_buf.size() > 0 && (!re || m_buf.size() == WB_DEPTH)) begin
            m_mem[m_buf[0].idx] = m_buf[0].data;
            void'(m_buf.pop_front());
        end
        if (we && ok) m_buf.push_back('{int'(a / 8), wd});
        if ((we || re) && !ok) m_err = 1'b1;
    endtask

    // One request cycle: drive, predict load data, step the model at the edge.
    task automatic step(input bit rst_n, input bit we, input bit re,
                        input logic [N-1:0] a, input logic [N-1:0] wd);
        st_t s;
        reset          = rst_n;
        DM_writeEnable = we;
        DM_readEnable  = re;
        DM_addr        = a;
        DM_writeData   = wd;
        if (re) rd_q.push_back(exp_read(rst_n, we, re, a));
        @(posedge clk);
        model_edge(rst_n, we, re, a, wd);
        s.cnt = m_buf.size();
        s.err = m_err;
        st_q.push_back(s);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: load data whenever a load is presented; status and storage after each edge.
    always @(negedge clk) begin
        if (DM_readEnable) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: load seen with no prediction, got %h", DM_readData);
            end else begin
                logic [N-1:0] e;
                e = rd_q.pop_front();
                if (DM_readData !== e) begin
                    errors++;
                    $display("FAIL rd_data: addr=%h got %h expected %h", DM_addr, DM_readData, e);
                end
            end
        end
        if (st_q.size() > 0) begin
            st_t s;
            int bad;
            s = st_q.pop_front();
            checks++;
            if (wb_count !== 3'(s.cnt)) begin
                errors++;
                $display("FAIL wb_count: got %0d expected %0d", wb_count, s.cnt);
            end
            checks++;
            if (access_err !== s.err) begin
                errors++;
                $display("FAIL access_err: got %0b expected %0b", access_err, s.err);
            end
            checks++;
            bad = -1;
            for (int i = 0; i < WORDS; i++)
                if (bad < 0 && dut.mem_q[i] !== m_mem[i]) bad = i;
            if (bad >= 0) begin
                errors++;
                $display("FAIL storage[%0d]: got %h expected %h", bad, dut.mem_q[bad], m_mem[bad]);
            end
        end
    end

    initial begin
        logic [N-1:0] a;
        int r;
        bit we, re;
        reset = 1'b0; DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
        DM_addr = '0; DM_writeData = '0;
        for (int i = 0; i < WORDS; i++) m_mem[i] = 'x;
        m_err = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b0, '0, '0);
        #1;

        // Reset state and plain load
        do_reset();
        step(1'b1, 1'b0, 1'b1, 64'h28, '0);

        // Store then forwarded load, then drain on idle
        step(1'b1, 1'b1, 1'b0, 64'h10, 64'hAA);
        step(1'b1, 1'b0, 1'b1, 64'h10, '0);
        idle();
        step(1'b1, 1'b0, 1'b1, 64'h10, '0);

        // Stores with load enable held high
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b1, 64'(8 * i), 64'h1000 + 64'(i));
        idle(); idle();
        do_reset();

        // Same-index stores: youngest forwarded and finally stored
        step(1'b1, 1'b1, 1'b0, 64'h30, 64'h1);
        step(1'b1, 1'b1, 1'b0, 64'h30, 64'h2);
        step(1'b1, 1'b0, 1'b1, 64'h30, '0);
        idle(); idle();
        step(1'b1, 1'b0, 1'b1, 64'h30, '0);

        // Misaligned load, out-of-range store, sticky flag
        step(1'b1, 1'b0, 1'b1, 64'h0C, '0);
        step(1'b1, 1'b1, 1'b0, 64'h200, 64'h55);
        idle(); idle();

        // Buffered stores discarded by reset
        do_reset();
        step(1'b1, 1'b1, 1'b0, 64'h00, 64'hDEAD);
        step(1'b1, 1'b1, 1'b0, 64'h08, 64'hBEEF);
        step(1'b1, 1'b1, 1'b0, 64'h18, 64'hCAFE);
        do_reset();
        step(1'b1, 1'b0, 1'b1, 64'h18, '0);

        // Randomized traffic over a small index set to exercise forwarding
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 19);
            we = (r == 0) || (r >= 1 && r <= 7);
            re = (r == 0) || (r >= 8 && r <= 14);
            case ($urandom_range(0, 9))
                0:       a = 64'($urandom_range(0, 63) * 8 + $urandom_range(1, 7));
                1:       a = 64'h200 + 64'($urandom_range(0, 255) * 8);
                default: a = 64'($urandom_range(0, 7) * 8);
            endcase
            if ($urandom_range(0, 39) == 0) step(1'b0, we, re, a, {$urandom, $urandom});
            else                            step(1'b1, we, re, a, {$urandom, $urandom});
        end
        idle();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
